// File: rtl/bnn_infer_ctrl_pkg.sv
// Purpose: shared state encoding, default sizes and small decode helpers for the BNN inference sequencer.
// Latency: n/a, types and constants only.
// Backpressure: n/a.
package bnn_infer_ctrl_pkg;

    localparam int INPUT_NUM_DEF  = 784;
    localparam int NEURON_NUM_DEF = 10;
    localparam int ADDR_W_DEF     = 10;
    localparam int NEU_W_DEF      = 4;

    // Nine phases, so the encoding needs four bits.
    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_REQ   = 4'd1,
        ST_ACK   = 4'd2,
        ST_LOAD  = 4'd3,
        ST_SND   = 4'd4,
        ST_RUN   = 4'd5,
        ST_WAITN = 4'd6,
        ST_REL   = 4'd7,
        ST_DONE  = 4'd8
    } state_e;

    // The image register is asked to hold its image from SND until REL.
    function automatic logic holds_image(input state_e s);
        return (s == ST_SND) || (s == ST_RUN) || (s == ST_WAITN);
    endfunction

    // A neuron index is presented from its start pulse until its done.
    function automatic logic neuron_active(input state_e s);
        return (s == ST_RUN) || (s == ST_WAITN);
    endfunction

endpackage

// File: rtl/bnn_infer_ctrl.sv
// Purpose: sequences one BNN inference: image-register load handshake, pixel streaming, per-neuron evaluation, result collection.
// Latency: start to done = 5 + INPUT_NUM + NEURON_NUM*(1+neuron latency) cycles plus any REQ/SND/REL handshake wait cycles.
// Backpressure: waits in REQ for img_rcv_req_i, in SND/REL for img_snd_ack_i, in WAITN for neu_done_i; start_i is ignored while busy.
//
// Ports:
//   clk_i, xrst_i          clock, synchronous active-high reset
//   start_i / busy_o       begin an inference (sampled in IDLE) / not idle
//   done_o, result_o       1-cycle completion pulse, neuron result bits (bit i = neuron i)
//   img_rcv_req_i/ack_o    image register ready to receive / start of image load
//   img_snd_req_o/ack_i    ask image register to hold its image / image held
//   pix_rd_o, pix_addr_o   pixel RAM read (data returns one cycle later)
//   neu_start_o, neu_idx_o neuron evaluation pulse and index
//   neu_done_i, neu_out_i  neuron finished and its result bit
module bnn_infer_ctrl
    import bnn_infer_ctrl_pkg::*;
#(
    parameter int INPUT_NUM  = INPUT_NUM_DEF,
    parameter int NEURON_NUM = NEURON_NUM_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int NEU_W      = NEU_W_DEF
) (
    input  logic                  clk_i,
    input  logic                  xrst_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [NEURON_NUM-1:0] result_o,
    input  logic                  img_rcv_req_i,
    output logic                  img_rcv_ack_o,
    output logic                  img_snd_req_o,
    input  logic                  img_snd_ack_i,
    output logic                  pix_rd_o,
    output logic [ADDR_W-1:0]     pix_addr_o,
    output logic                  neu_start_o,
    output logic [NEU_W-1:0]      neu_idx_o,
    input  logic                  neu_done_i,
    input  logic                  neu_out_i
);

    localparam logic [ADDR_W-1:0] K_LAST  = ADDR_W'(INPUT_NUM - 1);
    localparam logic [ADDR_W-1:0] K_ONE   = ADDR_W'(1);
    localparam logic [NEU_W-1:0]  N_LAST  = NEU_W'(NEURON_NUM - 1);
    localparam logic [NEU_W-1:0]  N_ONE   = NEU_W'(1);

    state_e                  state_q, state_d;
    logic [ADDR_W-1:0]       k_q, k_d;
    logic [NEU_W-1:0]        n_q, n_d;
    logic [NEURON_NUM-1:0]   result_q, result_d;

    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    rcv_ack_q, rcv_ack_d;
    logic                    snd_req_q, snd_req_d;
    logic                    pix_rd_q, pix_rd_d;
    logic [ADDR_W-1:0]       pix_addr_q, pix_addr_d;
    logic                    neu_start_q, neu_start_d;
    logic [NEU_W-1:0]        neu_idx_q, neu_idx_d;

    // Next-state, counters and result capture.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        n_d      = n_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d  = ST_REQ;
                    result_d = '0;
                end
            end
            ST_REQ: begin
                if (img_rcv_req_i) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_LOAD;
                k_d     = '0;
            end
            ST_LOAD: begin
                if (k_q == K_LAST) begin
                    state_d = ST_SND;
                    k_d     = '0;
                end else begin
                    k_d = k_q + K_ONE;
                end
            end
            ST_SND: begin
                if (img_snd_ack_i) begin
                    state_d = ST_RUN;
                    n_d     = '0;
                end
            end
            ST_RUN: begin
                // neu_done_i in the start cycle belongs to nothing we asked for.
                state_d = ST_WAITN;
            end
            ST_WAITN: begin
                if (neu_done_i) begin
                    result_d[n_q] = neu_out_i;
                    if (n_q == N_LAST) begin
                        state_d = ST_REL;
                    end else begin
                        n_d     = n_q + N_ONE;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_REL: begin
                if (!img_snd_ack_i) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so that the registered copy
    // lines up with the state it belongs to.
    always_comb begin
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
        rcv_ack_d   = (state_d == ST_ACK);
        snd_req_d   = holds_image(state_d);
        neu_start_d = (state_d == ST_RUN);
        neu_idx_d   = neuron_active(state_d) ? n_d : '0;
        pix_rd_d    = 1'b0;
        pix_addr_d  = '0;
        if (state_d == ST_ACK) begin
            pix_rd_d = 1'b1;
        end else if ((state_d == ST_LOAD) && (k_d != K_LAST)) begin
            // Prefetch pixel k+1 so it lands in LOAD cycle k+1.
            pix_rd_d   = 1'b1;
            pix_addr_d = k_d + K_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (xrst_i) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            n_q         <= '0;
            result_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rcv_ack_q   <= 1'b0;
            snd_req_q   <= 1'b0;
            pix_rd_q    <= 1'b0;
            pix_addr_q  <= '0;
            neu_start_q <= 1'b0;
            neu_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            n_q         <= n_d;
            result_q    <= result_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rcv_ack_q   <= rcv_ack_d;
            snd_req_q   <= snd_req_d;
            pix_rd_q    <= pix_rd_d;
            pix_addr_q  <= pix_addr_d;
            neu_start_q <= neu_start_d;
            neu_idx_q   <= neu_idx_d;
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign result_o      = result_q;
    assign img_rcv_ack_o = rcv_ack_q;
    assign img_snd_req_o = snd_req_q;
    assign pix_rd_o      = pix_rd_q;
    assign pix_addr_o    = pix_addr_q;
    assign neu_start_o   = neu_start_q;
    assign neu_idx_o     = neu_idx_q;

endmodule
